// File: rtl/pla_preimage_scanner_if.sv
// pla_preimage_scanner_if: probe, match-stream and status signals of the preimage scanner
interface pla_preimage_scanner_if;
  logic start, target, y0, m_ready;
  logic x0, x1, x2, x3, x4, x5;
  logic m_valid, busy, done;
  logic [5:0] m_vec;
  logic [6:0] count;
  modport master (
    input start, target, y0, m_ready,
    output x0, x1, x2, x3, x4, x5, m_valid, m_vec, count, busy, done
  );
  modport slave (
    output start, target, y0, m_ready,
    input x0, x1, x2, x3, x4, x5, m_valid, m_vec, count, busy, done
  );
endinterface

// File: rtl/pla_preimage_scanner.sv
// pla_preimage_scanner: walks all 64 inputs of a 6-in/1-out function and streams those whose output equals target
module pla_preimage_scanner (
  input logic clk,
  input logic rst_n,
  pla_preimage_scanner_if.master bus
);
  typedef enum logic [1:0] {IDLE, PROBE, EMIT, DONE} state_t;
  state_t state, state_d;
  logic [5:0] idx, idx_d, vec, vec_d;
  logic [6:0] cnt, cnt_d;
  logic tgt, tgt_d, vld, vld_d, last;
  assign last = idx == 6'd63;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      vec <= '0;
      cnt <= '0;
      tgt <= 1'b0;
      vld <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      vec <= vec_d;
      cnt <= cnt_d;
      tgt <= tgt_d;
      vld <= vld_d;
    end
  end
  always_comb begin
    state_d = state;
    idx_d = idx;
    vec_d = vec;
    cnt_d = cnt;
    tgt_d = tgt;
    vld_d = vld;
    case (state)
      IDLE: if (bus.start) begin
        idx_d = '0;
        cnt_d = '0;
        tgt_d = bus.target;
        state_d = PROBE;
      end
      PROBE: if (bus.y0 == tgt) begin
        vec_d = idx;
        vld_d = 1'b1;
        state_d = EMIT;
      end else begin
        idx_d = last ? idx : idx + 6'd1;
        state_d = last ? DONE : PROBE;
      end
      EMIT: if (bus.m_ready) begin
        cnt_d = cnt + 7'd1;
        vld_d = 1'b0;
        idx_d = last ? idx : idx + 6'd1;
        state_d = last ? DONE : PROBE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  assign {bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0} = idx;
  assign bus.m_valid = vld;
  assign bus.m_vec = vec;
  assign bus.count = cnt;
  assign bus.busy = state == PROBE || state == EMIT;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_pla_preimage_scanner.sv
// tb_pla_preimage_scanner: random truth tables scanned against a preimage-list reference model
module tb_pla_preimage_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pla_preimage_scanner_if bus();
  pla_preimage_scanner dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  logic [63:0] tt = '0;
  logic [5:0] xv;
  assign xv = {bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};
  assign bus.y0 = tt[xv];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, 32'(xv), 0);
    chk({tag, "_valid"}, 32'(bus.m_valid), 0);
    chk({tag, "_vec"}, 32'(bus.m_vec), 0);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask
  // stall<0: random m_ready; stall>=0: m_ready low for stall cycles of each match
  task automatic scan(input logic [63:0] f, input logic t, input int stall, input bit noise);
    int exp_q[$];
    int e, vcyc, emit_n, last_x, hs, xi;
    logic rdy;
    tt = f;
    for (int v = 0; v < 64; v++) if (f[v] == t) exp_q.push_back(v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.target = t;
    bus.m_ready = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    bus.target = ~t;
    e = cyc;
    vcyc = 0;
    emit_n = 0;
    last_x = -1;
    hs = 0;
    for (int n = 0; n < 2000 && !bus.done; n++) begin
      xi = int'(xv);
      chk("x_step", 32'(xi == last_x + 1 || (xi == last_x && bus.m_valid)), 1);
      chk("busy", 32'(bus.busy), 1);
      if (bus.m_valid) begin
        chk("vec_order", 32'(bus.m_vec), hs < exp_q.size() ? 32'(exp_q[hs]) : 32'hffff);
        chk("vec_is_x", 32'(bus.m_vec), 32'(xv));
        vcyc++;
      end
      last_x = xi;
      rdy = bus.m_valid ? (stall < 0 ? 1'($urandom) : emit_n >= stall)
                        : (stall == 0 ? 1'b1 : 1'($urandom));
      if (bus.m_valid) begin
        if (rdy) begin
          hs++;
          emit_n = 0;
        end else emit_n++;
      end
      bus.m_ready = rdy;
      bus.start = noise && $urandom_range(0, 7) == 0;
      bus.target = noise ? 1'($urandom) : bus.target;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(bus.done), 1);
    chk("done_cycle", 32'(cyc - e), 32'(64 + vcyc));
    chk("last_x", 32'(last_x), 63);
    chk("hs_count", 32'(hs), 32'(exp_q.size()));
    chk("count", 32'(bus.count), 32'(exp_q.size()));
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_valid", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 0);
    @(negedge clk);
    chk("count_hold", 32'(bus.count), 32'(exp_q.size()));
    chk("idle_busy", 32'(bus.busy), 0);
  endtask
  task automatic reset_mid_emit();
    bit hit;
    tt = 64'($urandom) | (64'd1 << 9);
    hit = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.target = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      hit = bus.m_valid && bus.m_vec == 6'd9;
      bus.m_ready = !hit;
      if (!hit) @(negedge clk);
    end
    chk("reach_vec9", 32'(hit), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("rst_emit");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst_release");
  endtask
  initial begin
    bus.start = 1'b0;
    bus.target = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    scan(64'd0, 1'b1, 0, 1'b0);
    scan(~64'd0, 1'b1, 0, 1'b0);
    scan(64'haaaa_aaaa_aaaa_aaaa, 1'b1, 0, 1'b0);
    scan(64'd1 << 5, 1'b1, 5, 1'b0);
    reset_mid_emit();
    scan({$urandom, $urandom}, 1'b1, -1, 1'b1);
    scan(~64'd0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 8; k++)
      scan({$urandom, $urandom} & {$urandom, $urandom}, 1'($urandom),
           $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 3)), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pla_preimage_scanner.md
PLA_PREIMAGE_SCANNER -- requirements
Module: pla_preimage_scanner

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-004 target  input  1  output value being searched for; captured when start is accepted.
REQ-005 x0..x5  output  1 each  probe vector driven to the 6-input/1-output function under test; x0 is the LSB of the scan index.
REQ-006 y0  input  1  function response to x0..x5; combinational, valid in the same cycle.
REQ-007 m_valid  output  1  a matching vector is presented.
REQ-008 m_ready  input  1  consumer accepts the vector.
REQ-009 m_vec  output  6  matching input vector, {x5..x0} order.
REQ-010 count  output  7  number of vectors accepted in the current or last scan, 0..64.
REQ-011 busy  output  1  high in PROBE and EMIT.
REQ-012 done  output  1  one-cycle pulse at scan end.

Function
REQ-013 The FSM SHALL have four states: IDLE, PROBE, EMIT and DONE.
REQ-014 IDLE: start=1 at a clock edge SHALL set idx to 0, count to 0 and tgt to target, and SHALL move to PROBE.
REQ-015 x0..x5 SHALL always equal the registered 6-bit idx.
REQ-016 PROBE, y0==tgt at the edge: load m_vec with idx, set m_valid, go to EMIT.
REQ-017 PROBE, y0!=tgt and idx==63: go to DONE.
REQ-018 PROBE, y0!=tgt and idx<63: increment idx and stay in PROBE.
REQ-019 Each probe SHALL take exactly one cycle.
REQ-020 EMIT: m_valid, m_vec and idx SHALL remain stable until m_valid&m_ready is sampled at a clock edge.
REQ-021 On a handshake, the block SHALL increment count, clear m_valid, and then go to DONE if idx==63, otherwise increment idx and go to PROBE.
REQ-022 m_valid SHALL be asserted only in EMIT.
REQ-023 m_ready SHALL be ignored outside EMIT.
REQ-024 A handshake SHALL cost exactly one extra cycle beyond the probe when m_ready=1.
REQ-025 DONE: done SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-026 count SHALL hold its value in IDLE until the next accepted start.
REQ-027 idx SHALL never wrap within a scan; 64 vectors SHALL be probed exactly once each, in ascending order.
REQ-028 count SHALL be 7 bits wide so that 64 is representable without saturation logic.
REQ-029 start SHALL be ignored in PROBE, EMIT and DONE.
REQ-030 A change of target mid-scan SHALL have no effect on the scan in progress.
REQ-031 busy SHALL be 1 exactly when the state is PROBE or EMIT.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE from any state, including in the middle of PROBE or EMIT, and SHALL drop any pending vector without a handshake.
REQ-033 During and after reset: x0..x5=0, m_valid=0, m_vec=0, count=0, busy=0, done=0, tgt=0.
REQ-034 The first accepted start after reset SHALL behave identically to any other start.

Verification
REQ-035 Function y0=0, target=1, start at edge E -> no m_valid; PROBE for 64 cycles; done=1 in cycle E+65; count=0.
REQ-036 Function y0=1, target=1, m_ready tied high -> 64 handshakes with m_vec=0,1,...,63 in order; done in cycle E+129; count=64.
REQ-037 Function y0=x0, target=1, m_ready tied high -> m_vec=1,3,5,...,63; count=32; done follows the handshake for vector 63 by one cycle.
REQ-038 Function y0=(vec==5), target=1, m_ready held low 5 cycles after m_valid rises -> m_valid=1 and m_vec=5 stable for all 5 cycles; handshake on the 6th cycle; count=1; done in cycle E+71.
REQ-039 rst_n=0 during EMIT of vector 9 -> next cycle m_valid=0, busy=0, count=0, x=0; a fresh start rescans from vector 0.
REQ-040 A second start pulse while busy -> ignored: idx sequence uninterrupted and a single done pulse.
